// File: rtl/fast_biquad_pkg.sv
// fast_biquad_pkg
// Shared sizing helpers and the output quantiser for the fast_biquad filter.
//   frac_bits  : number of fractional coefficient bits (Q2.F format).
//   acc_width  : accumulator width that holds any sum of five exact products.
//   round_sat  : round half up, arithmetic shift by F, clamp to the sample range.
package fast_biquad_pkg;

    // Wide working width for the quantiser; any accumulator is sign-extended into it.
    localparam int WIDE_W = 64;

    function automatic int frac_bits(input int coef_width);
        return coef_width - 2;
    endfunction

    function automatic int acc_width(input int sample_width, input int coef_width);
        return sample_width + coef_width + 3;
    endfunction

    // Result is a clamped value in WIDE_W bits; callers keep the low sample bits.
    function automatic logic signed [WIDE_W-1:0] round_sat(
        input logic signed [WIDE_W-1:0] acc,
        input int                       frac,
        input int                       sample_width
    );
        logic signed [WIDE_W-1:0] rounded;
        logic signed [WIDE_W-1:0] hi;
        logic signed [WIDE_W-1:0] lo;
        rounded = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
        hi      = (64'sd1 <<< (sample_width - 1)) - 64'sd1;
        lo      = -(64'sd1 <<< (sample_width - 1));
        if (rounded > hi) begin
            rounded = hi;
        end else if (rounded < lo) begin
            rounded = lo;
        end
        return rounded;
    endfunction

endpackage

// File: rtl/fast_biquad_mac.sv
// biquad_mac
// Exact signed sum of three coefficient x sample products (combinational).
//   coef[0..2] : signed COEF_WIDTH coefficients
//   samp[0..2] : signed SAMPLE_WIDTH samples
//   sum        : signed ACC_WIDTH exact result
module biquad_mac #(
    parameter int SAMPLE_WIDTH = 8,
    parameter int COEF_WIDTH   = 16,
    parameter int ACC_WIDTH    = 27
) (
    input  logic signed [COEF_WIDTH-1:0]   coef [3],
    input  logic signed [SAMPLE_WIDTH-1:0] samp [3],
    output logic signed [ACC_WIDTH-1:0]    sum
);

    localparam int PROD_W = SAMPLE_WIDTH + COEF_WIDTH;

    logic signed [PROD_W-1:0] prod [3];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_prod
            // Both operands signed and sized to PROD_W, so the product is exact.
            assign prod[gi] = coef[gi] * samp[gi];
        end
    endgenerate

    assign sum = ACC_WIDTH'(prod[0]) + ACC_WIDTH'(prod[1]) + ACC_WIDTH'(prod[2]);

endmodule

// File: rtl/fast_biquad.sv
// fast_biquad
// Two-stage pipelined direct-form-I biquad, one sample per clock, latency 2.
//   clk, reset          : clock and synchronous active-high reset
//   b0, b1, b2, a1, a2  : live signed Q2.(COEF_WIDTH-2) coefficients
//   in, in_valid        : input sample x[n] and its qualifier
//   out, out_valid      : saturated filtered sample y[n] and its qualifier
module fast_biquad
    import fast_biquad_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 8,
    parameter int COEF_WIDTH   = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic signed [COEF_WIDTH-1:0]   b0,
    input  logic signed [COEF_WIDTH-1:0]   b1,
    input  logic signed [COEF_WIDTH-1:0]   b2,
    input  logic signed [COEF_WIDTH-1:0]   a1,
    input  logic signed [COEF_WIDTH-1:0]   a2,
    input  logic signed [SAMPLE_WIDTH-1:0] in,
    input  logic                           in_valid,
    output logic signed [SAMPLE_WIDTH-1:0] out,
    output logic                           out_valid
);

    localparam int F     = frac_bits(COEF_WIDTH);
    localparam int ACC_W = acc_width(SAMPLE_WIDTH, COEF_WIDTH);

    logic signed [SAMPLE_WIDTH-1:0] x1_reg, x2_reg;
    logic signed [SAMPLE_WIDTH-1:0] y1_reg, y2_reg, out_reg;
    logic signed [ACC_W-1:0]        ff_reg;
    logic                           v1_reg, out_valid_reg;

    logic signed [COEF_WIDTH-1:0]   ff_coef [3];
    logic signed [SAMPLE_WIDTH-1:0] ff_samp [3];
    logic signed [COEF_WIDTH-1:0]   fb_coef [3];
    logic signed [SAMPLE_WIDTH-1:0] fb_samp [3];
    logic signed [ACC_W-1:0]        ff_next;
    logic signed [ACC_W-1:0]        fb_sum;
    logic signed [ACC_W-1:0]        acc_next;
    logic signed [SAMPLE_WIDTH-1:0] y_next;

    assign ff_coef[0] = b0;
    assign ff_coef[1] = b1;
    assign ff_coef[2] = b2;
    assign ff_samp[0] = in;
    assign ff_samp[1] = x1_reg;
    assign ff_samp[2] = x2_reg;

    // Feedback uses only two taps; the third slot is tied off.
    assign fb_coef[0] = a1;
    assign fb_coef[1] = a2;
    assign fb_coef[2] = '0;
    assign fb_samp[0] = y1_reg;
    assign fb_samp[1] = y2_reg;
    assign fb_samp[2] = '0;

    biquad_mac #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .COEF_WIDTH   (COEF_WIDTH),
        .ACC_WIDTH    (ACC_W)
    ) u_ff_mac (
        .coef (ff_coef),
        .samp (ff_samp),
        .sum  (ff_next)
    );

    biquad_mac #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .COEF_WIDTH   (COEF_WIDTH),
        .ACC_WIDTH    (ACC_W)
    ) u_fb_mac (
        .coef (fb_coef),
        .samp (fb_samp),
        .sum  (fb_sum)
    );

    // Subtract at full accumulator width rather than negating a1/a2:
    // negating -2.0 would not fit back into COEF_WIDTH bits.
    assign acc_next = ff_reg - fb_sum;
    assign y_next   = SAMPLE_WIDTH'(round_sat(WIDE_W'(acc_next), F, SAMPLE_WIDTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            x1_reg        <= '0;
            x2_reg        <= '0;
            ff_reg        <= '0;
            v1_reg        <= 1'b0;
            y1_reg        <= '0;
            y2_reg        <= '0;
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            // Stage 1: feedforward sum and input history advance on valid samples only.
            if (in_valid) begin
                ff_reg <= ff_next;
                x2_reg <= x1_reg;
                x1_reg <= in;
            end
            v1_reg <= in_valid;

            // Stage 2: single-cycle recursion on the saturated outputs.
            if (v1_reg) begin
                out_reg <= y_next;
                y2_reg  <= y1_reg;
                y1_reg  <= y_next;
            end
            out_valid_reg <= v1_reg;
        end
    end

    assign out       = out_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_fast_biquad.sv
// tb_fast_biquad
// Directed checks of fast_biquad (Q2.14 coefficients: 16384 = 1.0).
module tb_fast_biquad;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [15:0] b0, b1, b2, a1, a2;
    logic signed [7:0]  in_s;
    logic               in_valid;
    logic signed [7:0]  out_s;
    logic               out_valid;

    int n_cmp = 0;
    int n_bad = 0;

    fast_biquad #(
        .SAMPLE_WIDTH (8),
        .COEF_WIDTH   (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .b0        (b0),
        .b1        (b1),
        .b2        (b2),
        .a1        (a1),
        .a2        (a2),
        .in        (in_s),
        .in_valid  (in_valid),
        .out       (out_s),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Drive one cycle of input, then land 1 time unit after the rising edge.
    task automatic step(input logic v, input logic signed [7:0] x);
        in_valid = v;
        in_s     = x;
        @(posedge clk);
        #1;
    endtask

    task automatic set_coefs(input logic signed [15:0] c_b0, input logic signed [15:0] c_b1,
                             input logic signed [15:0] c_b2, input logic signed [15:0] c_a1,
                             input logic signed [15:0] c_a2);
        b0 = c_b0; b1 = c_b1; b2 = c_b2; a1 = c_a1; a2 = c_a2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b1, 8'sd77);
        step(1'b1, 8'sd77);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        set_coefs(16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0);
        do_reset();
        n_cmp++;
        if (out_s !== 8'sd0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: out=%0d out_valid=%0b, want 0/0", out_s, out_valid);
        end
        // All-zero coefficients: full-scale input must still give 0.
        step(1'b1, -8'sd128);
        step(1'b1, 8'sd127);
        n_cmp++;
        if (out_s !== 8'sd0 || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL zero_coefs: out=%0d out_valid=%0b, want 0/1", out_s, out_valid);
        end
        $display("test_reset done");
    endtask

    task automatic test_identity();
        logic signed [7:0] xs [8] = '{8'sd63, -8'sd64, 8'sd63, -8'sd64, 8'sd63, -8'sd64, 8'sd63, -8'sd64};
        set_coefs(16'sd16384, 16'sd0, 16'sd0, 16'sd0, 16'sd0);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, xs[i]);
            n_cmp++;
            if (i == 0) begin
                if (out_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL identity_latency: out_valid=%0b, want 0", out_valid);
                end
            end else if (out_s !== xs[i-1] || out_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL identity[%0d]: out=%0d v=%0b, want %0d/1", i, out_s, out_valid, xs[i-1]);
            end
        end
        $display("test_identity done");
    endtask

    task automatic test_delay();
        logic signed [7:0] xs [5]  = '{8'sd100, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
        logic signed [7:0] ys [5]  = '{8'sd0, 8'sd100, 8'sd0, 8'sd0, 8'sd0};
        set_coefs(16'sd0, 16'sd16384, 16'sd0, 16'sd0, 16'sd0);
        do_reset();
        step(1'b1, xs[0]);
        for (int i = 1; i < 5; i++) begin
            step(1'b1, xs[i]);
            n_cmp++;
            if (out_s !== ys[i-1] || out_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL delay[%0d]: out=%0d v=%0b, want %0d/1", i-1, out_s, out_valid, ys[i-1]);
            end
        end
        $display("test_delay done");
    endtask

    task automatic test_recursion();
        // a1 = -0.5: y[n] = x[n] + 0.5*y[n-1]; 0.5 rounds half up to 1.
        logic signed [7:0] ys [10] = '{8'sd64, 8'sd32, 8'sd16, 8'sd8, 8'sd4, 8'sd2, 8'sd1, 8'sd1, 8'sd1, 8'sd1};
        set_coefs(16'sd16384, 16'sd0, 16'sd0, -16'sd8192, 16'sd0);
        do_reset();
        step(1'b1, 8'sd64);
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 8'sd0);
            n_cmp++;
            if (out_s !== ys[i-1] || out_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL recursion[%0d]: out=%0d v=%0b, want %0d/1", i-1, out_s, out_valid, ys[i-1]);
            end
        end
        $display("test_recursion done");
    endtask

    task automatic test_saturation();
        set_coefs(16'sd32767, 16'sd0, 16'sd0, 16'sd0, 16'sd0);
        do_reset();
        step(1'b1, 8'sd127);
        step(1'b1, -8'sd128);
        n_cmp++;
        if (out_s !== 8'sd127) begin
            n_bad++;
            $display("FAIL sat_pos: out=%0d, want 127", out_s);
        end
        b0 = -16'sd32768;
        step(1'b1, -8'sd128);
        n_cmp++;
        if (out_s !== -8'sd128) begin
            n_bad++;
            $display("FAIL sat_neg: out=%0d, want -128", out_s);
        end
        step(1'b1, 8'sd127);
        n_cmp++;
        if (out_s !== 8'sd127) begin
            n_bad++;
            $display("FAIL sat_minus2_min: out=%0d, want 127", out_s);
        end
        step(1'b0, 8'sd0);
        n_cmp++;
        if (out_s !== -8'sd128 || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_minus2_max: out=%0d v=%0b, want -128/1", out_s, out_valid);
        end
        step(1'b0, 8'sd0);
        n_cmp++;
        if (out_s !== -8'sd128 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL sat_hold: out=%0d v=%0b, want -128/0", out_s, out_valid);
        end
        $display("test_saturation done");
    endtask

    task automatic test_default();
        // b1=b2=0.25, a1=a2=0.5; DC gain 0.5/2 gives about 15.75 for 63.
        logic signed [7:0] first [4] = '{8'sd0, 8'sd16, 8'sd24, 8'sd12};
        set_coefs(16'sd0, 16'sd4096, 16'sd4096, 16'sd8192, 16'sd8192);
        do_reset();
        step(1'b1, 8'sd63);
        for (int i = 1; i < 50; i++) begin
            step(1'b1, 8'sd63);
            if (i <= 4) begin
                n_cmp++;
                if (out_s !== first[i-1]) begin
                    n_bad++;
                    $display("FAIL default_start[%0d]: out=%0d, want %0d", i-1, out_s, first[i-1]);
                end
            end
            n_cmp++;
            if (out_s < -8'sd127) begin
                n_bad++;
                $display("FAIL default_bound[%0d]: out=%0d, want within +-127", i-1, out_s);
            end
        end
        n_cmp++;
        if (out_s < 8'sd15 || out_s > 8'sd17) begin
            n_bad++;
            $display("FAIL default_settle: out=%0d, want 15..17", out_s);
        end
        $display("test_default done");
    endtask

    task automatic test_gaps();
        logic              vs [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic              ev [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic signed [7:0] xs [8] = '{8'sd40, 8'sd99, 8'sd0, 8'sd99, 8'sd99, 8'sd0, 8'sd99, 8'sd99};
        logic signed [7:0] eo [8] = '{8'sd0, 8'sd40, 8'sd40, 8'sd20, 8'sd20, 8'sd20, 8'sd10, 8'sd10};
        set_coefs(16'sd16384, 16'sd0, 16'sd0, -16'sd8192, 16'sd0);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(vs[i], xs[i]);
            n_cmp++;
            if (out_s !== eo[i] || out_valid !== ev[i]) begin
                n_bad++;
                $display("FAIL gaps[%0d]: out=%0d v=%0b, want %0d/%0b", i, out_s, out_valid, eo[i], ev[i]);
            end
        end
        $display("test_gaps done");
    endtask

    task automatic test_mid_reset();
        set_coefs(16'sd16384, 16'sd16384, 16'sd0, 16'sd0, 16'sd0);
        do_reset();
        step(1'b1, 8'sd50);
        step(1'b1, 8'sd60);
        n_cmp++;
        if (out_s !== 8'sd50 || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_pre: out=%0d v=%0b, want 50/1", out_s, out_valid);
        end
        reset = 1'b1;
        step(1'b1, 8'sd70);
        n_cmp++;
        if (out_s !== 8'sd0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_clear: out=%0d v=%0b, want 0/0", out_s, out_valid);
        end
        step(1'b1, 8'sd70);
        reset = 1'b0;
        step(1'b1, 8'sd30);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_flush: out_valid=%0b, want 0", out_valid);
        end
        step(1'b0, 8'sd0);
        n_cmp++;
        if (out_s !== 8'sd30 || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_zero_history: out=%0d v=%0b, want 30/1", out_s, out_valid);
        end
        $display("test_mid_reset done");
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_s     = '0;
        set_coefs(16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0);
        test_reset();
        test_identity();
        test_delay();
        test_recursion();
        test_saturation();
        test_default();
        test_gaps();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
